// File: rtl/obj_move_pkg.sv
// Shared definitions for the sprite mover: FSM states, edge-code bit
// positions and the playfield limit helper.
package obj_move_pkg;

    typedef enum logic [2:0] {
        INIT_ST     = 3'd0,
        WAIT_SOF_ST = 3'd1,
        SPEED_ST    = 3'd2,
        POS_ST      = 3'd3,
        LIMIT_ST    = 3'd4
    } move_state_t;

    // Bit positions inside HitEdgeCode and the sticky edge latch.
    localparam int EDGE_LEFT   = 3;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_BOTTOM = 0;

    // Largest legal top-left coordinate (in pixels) along one axis.
    function automatic int frame_limit(input int screen, input int obj, input int margin);
        return screen - 1 - margin - obj;
    endfunction

endpackage

// File: rtl/object_move_gen_speed_ramp.sv
// One-axis speed ramp: steps the current speed toward the target by ACCEL
// and lands exactly on the target rather than overshooting it.
module speed_ramp #(
    parameter int ACCEL = 16
) (
    input  logic signed [31:0] speed,
    input  logic signed [31:0] target,
    output logic signed [31:0] speed_next
);

    localparam logic signed [31:0] ACCEL_S = 32'(ACCEL);

    logic signed [31:0] inc_s;
    logic signed [31:0] dec_s;

    assign inc_s = speed + ACCEL_S;
    assign dec_s = speed - ACCEL_S;

    // Choose the one-step move toward target, saturating at the target.
    always_comb begin
        speed_next = target;
        if (speed < target) begin
            if (inc_s > target) begin
                speed_next = target;
            end else begin
                speed_next = inc_s;
            end
        end else if (speed > target) begin
            if (dec_s < target) begin
                speed_next = target;
            end else begin
                speed_next = dec_s;
            end
        end else begin
            speed_next = target;
        end
    end

endmodule

// File: rtl/object_move_gen.sv
// Per-frame sprite mover: fixed-point position/speed with speed ramping,
// optional gravity/jump, sticky collision edges, freeze and restart.
module object_move_gen
    import obj_move_pkg::*;
#(
    parameter int POS_W      = 11,
    parameter int FRAC_BITS  = 6,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int OBJ_W      = 32,
    parameter int OBJ_H      = 32,
    parameter int MARGIN     = 2,
    parameter int INIT_X     = 280,
    parameter int INIT_Y     = 185,
    parameter int MAX_SPEED  = 64,
    parameter int ACCEL      = 16,
    parameter int GRAVITY_EN = 0,
    parameter int GRAVITY    = 8,
    parameter int MAX_FALL   = 512,
    parameter int JUMP_SPEED = 320
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    startOfFrame,
    input  logic                    up_key_pressed,
    input  logic                    down_key_pressed,
    input  logic                    left_key_pressed,
    input  logic                    right_key_pressed,
    input  logic                    collision,
    input  logic [3:0]              HitEdgeCode,
    input  logic                    freeze,
    input  logic                    restart,
    output logic signed [POS_W-1:0] topLeftX,
    output logic signed [POS_W-1:0] topLeftY,
    output logic                    moving,
    output logic                    grounded
);

    localparam int FP_ONE = 1 << FRAC_BITS;
    localparam logic signed [31:0] INIT_X_FP  = 32'(INIT_X * FP_ONE);
    localparam logic signed [31:0] INIT_Y_FP  = 32'(INIT_Y * FP_ONE);
    localparam logic signed [31:0] MIN_FP     = 32'(MARGIN * FP_ONE);
    localparam logic signed [31:0] X_MAX_FP   = 32'(frame_limit(SCREEN_W, OBJ_W, MARGIN) * FP_ONE);
    localparam logic signed [31:0] Y_MAX_FP   = 32'(frame_limit(SCREEN_H, OBJ_H, MARGIN) * FP_ONE);
    localparam logic signed [31:0] MAX_SPD_S  = 32'(MAX_SPEED);
    localparam logic signed [31:0] GRAVITY_S  = 32'(GRAVITY);
    localparam logic signed [31:0] MAX_FALL_S = 32'(MAX_FALL);
    localparam logic signed [31:0] JUMP_S     = 32'(JUMP_SPEED);
    localparam logic signed [31:0] ZERO_S     = 32'sd0;

    move_state_t        state_r, fsm_nxt_s, state_d_s;
    logic signed [31:0] xpos_r, ypos_r, xspd_r, yspd_r;
    logic signed [31:0] xpos_nxt_s, ypos_nxt_s, xspd_nxt_s, yspd_nxt_s;
    logic signed [31:0] tgt_x_s, tgt_y_s, xramp_s, yramp_s, ygrav_s;
    logic signed [31:0] xspd_tmp_s, yspd_tmp_s;
    logic [3:0]         edge_r, edge_keep_s;
    logic               grounded_r, grounded_nxt_s, grnd_tmp_s;
    logic               prev_up_r, prev_up_nxt_s;
    logic               ybot_s;

    // Exactly one key of a pair selects a direction; none or both means stop.
    assign tgt_x_s = (right_key_pressed && !left_key_pressed) ? MAX_SPD_S :
                     ((left_key_pressed && !right_key_pressed) ? -MAX_SPD_S : ZERO_S);
    assign tgt_y_s = (down_key_pressed && !up_key_pressed) ? MAX_SPD_S :
                     ((up_key_pressed && !down_key_pressed) ? -MAX_SPD_S : ZERO_S);
    assign ygrav_s = yspd_r + GRAVITY_S;

    speed_ramp #(.ACCEL(ACCEL)) u_ramp_x (
        .speed      (xspd_r),
        .target     (tgt_x_s),
        .speed_next (xramp_s)
    );

    speed_ramp #(.ACCEL(ACCEL)) u_ramp_y (
        .speed      (yspd_r),
        .target     (tgt_y_s),
        .speed_next (yramp_s)
    );

    // Frame sequencer and datapath next-state computation.
    always_comb begin
        fsm_nxt_s      = state_r;
        xpos_nxt_s     = xpos_r;
        ypos_nxt_s     = ypos_r;
        xspd_nxt_s     = xspd_r;
        yspd_nxt_s     = yspd_r;
        grounded_nxt_s = grounded_r;
        prev_up_nxt_s  = prev_up_r;
        xspd_tmp_s     = xspd_r;
        yspd_tmp_s     = yspd_r;
        grnd_tmp_s     = grounded_r;
        ybot_s         = 1'b0;
        case (state_r)
            INIT_ST: begin
                xpos_nxt_s     = INIT_X_FP;
                ypos_nxt_s     = INIT_Y_FP;
                xspd_nxt_s     = ZERO_S;
                yspd_nxt_s     = ZERO_S;
                grounded_nxt_s = 1'b0;
                fsm_nxt_s      = WAIT_SOF_ST;
            end
            WAIT_SOF_ST: begin
                if (startOfFrame && !freeze) begin
                    fsm_nxt_s = SPEED_ST;
                end else begin
                    fsm_nxt_s = WAIT_SOF_ST;
                end
            end
            SPEED_ST: begin
                xspd_tmp_s = xramp_s;
                if (GRAVITY_EN != 0) begin
                    // A jump needs a fresh up press while standing on something.
                    if (up_key_pressed && !prev_up_r && grounded_r) begin
                        yspd_tmp_s = -JUMP_S;
                        grnd_tmp_s = 1'b0;
                    end else if (ygrav_s > MAX_FALL_S) begin
                        yspd_tmp_s = MAX_FALL_S;
                    end else begin
                        yspd_tmp_s = ygrav_s;
                    end
                end else begin
                    yspd_tmp_s = yramp_s;
                end
                // Latched edges kill only the speed component heading into them.
                if (edge_r[EDGE_LEFT] && (xspd_tmp_s < ZERO_S)) begin
                    xspd_nxt_s = ZERO_S;
                end else if (edge_r[EDGE_RIGHT] && (xspd_tmp_s > ZERO_S)) begin
                    xspd_nxt_s = ZERO_S;
                end else begin
                    xspd_nxt_s = xspd_tmp_s;
                end
                if (edge_r[EDGE_TOP] && (yspd_tmp_s < ZERO_S)) begin
                    yspd_nxt_s = ZERO_S;
                end else if (edge_r[EDGE_BOTTOM] && (yspd_tmp_s > ZERO_S)) begin
                    yspd_nxt_s = ZERO_S;
                end else begin
                    yspd_nxt_s = yspd_tmp_s;
                end
                if (edge_r[EDGE_BOTTOM] && (GRAVITY_EN != 0)) begin
                    grounded_nxt_s = 1'b1;
                end else begin
                    grounded_nxt_s = grnd_tmp_s;
                end
                prev_up_nxt_s = up_key_pressed;
                fsm_nxt_s     = POS_ST;
            end
            POS_ST: begin
                xpos_nxt_s = xpos_r + xspd_r;
                ypos_nxt_s = ypos_r + yspd_r;
                fsm_nxt_s  = LIMIT_ST;
            end
            LIMIT_ST: begin
                if (xpos_r < MIN_FP) begin
                    xpos_nxt_s = MIN_FP;
                    xspd_nxt_s = (xspd_r < ZERO_S) ? ZERO_S : xspd_r;
                end else if (xpos_r > X_MAX_FP) begin
                    xpos_nxt_s = X_MAX_FP;
                    xspd_nxt_s = (xspd_r > ZERO_S) ? ZERO_S : xspd_r;
                end else begin
                    xpos_nxt_s = xpos_r;
                    xspd_nxt_s = xspd_r;
                end
                if (ypos_r < MIN_FP) begin
                    ypos_nxt_s = MIN_FP;
                    yspd_nxt_s = (yspd_r < ZERO_S) ? ZERO_S : yspd_r;
                end else if (ypos_r > Y_MAX_FP) begin
                    ypos_nxt_s = Y_MAX_FP;
                    yspd_nxt_s = (yspd_r > ZERO_S) ? ZERO_S : yspd_r;
                    ybot_s     = 1'b1;
                end else begin
                    ypos_nxt_s = ypos_r;
                    yspd_nxt_s = yspd_r;
                end
                // Floor contact grounds the sprite; falling freely ungrounds it.
                if (GRAVITY_EN != 0) begin
                    if (ybot_s) begin
                        grounded_nxt_s = 1'b1;
                    end else if (yspd_r > ZERO_S) begin
                        grounded_nxt_s = 1'b0;
                    end else begin
                        grounded_nxt_s = grounded_r;
                    end
                end else begin
                    grounded_nxt_s = 1'b0;
                end
                fsm_nxt_s = WAIT_SOF_ST;
            end
            default: begin
                fsm_nxt_s = INIT_ST;
            end
        endcase
    end

    // Restart beats every other transition, including freeze.
    assign state_d_s = restart ? INIT_ST : fsm_nxt_s;

    // Edges accumulate until consumed by SPEED_ST; a same-cycle hit survives.
    assign edge_keep_s = (state_r == SPEED_ST) ? 4'b0000 : edge_r;

    // Sticky collision-edge latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_r <= 4'b0000;
        end else begin
            edge_r <= edge_keep_s | (collision ? HitEdgeCode : 4'b0000);
        end
    end

    // State, position, speed and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= INIT_ST;
            xpos_r     <= ZERO_S;
            ypos_r     <= ZERO_S;
            xspd_r     <= ZERO_S;
            yspd_r     <= ZERO_S;
            grounded_r <= 1'b0;
            prev_up_r  <= 1'b0;
        end else begin
            state_r    <= state_d_s;
            xpos_r     <= xpos_nxt_s;
            ypos_r     <= ypos_nxt_s;
            xspd_r     <= xspd_nxt_s;
            yspd_r     <= yspd_nxt_s;
            grounded_r <= grounded_nxt_s;
            prev_up_r  <= prev_up_nxt_s;
        end
    end

    // Pixel outputs are the floored fixed-point positions.
    assign topLeftX = POS_W'(xpos_r >>> FRAC_BITS);
    assign topLeftY = POS_W'(ypos_r >>> FRAC_BITS);
    assign moving   = (xspd_r != ZERO_S) || (yspd_r != ZERO_S);
    assign grounded = grounded_r;

endmodule

// File: tb/tb_object_move_gen.sv
// Bench for object_move_gen: a free-mode and a gravity-mode instance share
// stimulus; a per-frame reference model predicts both.
`timescale 1ns/1ps
module tb_object_move_gen;

    localparam int FP   = 64;
    localparam int XMIN = 2 * FP;
    localparam int XMAX = 605 * FP;
    localparam int YMIN = 2 * FP;
    localparam int YMAX = 445 * FP;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic startOfFrame = 1'b0;
    logic up_k = 1'b0, down_k = 1'b0, left_k = 1'b0, right_k = 1'b0;
    logic collision = 1'b0;
    logic [3:0] hit = 4'b0000;
    logic freeze = 1'b0;
    logic restart = 1'b0;
    logic signed [10:0] xf, yf, xg, yg;
    logic mf, gf, mg, gg;

    always #5 clk = ~clk;

    object_move_gen dut_f (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .up_key_pressed(up_k), .down_key_pressed(down_k),
        .left_key_pressed(left_k), .right_key_pressed(right_k),
        .collision(collision), .HitEdgeCode(hit), .freeze(freeze), .restart(restart),
        .topLeftX(xf), .topLeftY(yf), .moving(mf), .grounded(gf)
    );

    object_move_gen #(.GRAVITY_EN(1)) dut_g (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .up_key_pressed(up_k), .down_key_pressed(down_k),
        .left_key_pressed(left_k), .right_key_pressed(right_k),
        .collision(collision), .HitEdgeCode(hit), .freeze(freeze), .restart(restart),
        .topLeftX(xg), .topLeftY(yg), .moving(mg), .grounded(gg)
    );

    int tests = 0;
    int fails = 0;

    // Reference model, index 0 = free mode, 1 = gravity mode (fixed point).
    int mx[2], my[2], mvx[2], mvy[2];
    bit mgr[2], mpu[2];
    logic [3:0] pend;

    typedef struct {
        logic [3:0] keys;   // {up, down, left, right}
        int         ex;
        int         ey;
        logic       emov;
    } vec_t;
    vec_t tbl [13];

    int xhold, yhold;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int ramp(input int v, input int t);
        if (v < t) return (v + 16 > t) ? t : v + 16;
        else if (v > t) return (v - 16 < t) ? t : v - 16;
        else return t;
    endfunction

    task automatic model_init(input bit full);
        for (int g = 0; g < 2; g++) begin
            mx[g] = 280 * FP; my[g] = 185 * FP;
            mvx[g] = 0; mvy[g] = 0; mgr[g] = 1'b0;
            if (full) mpu[g] = 1'b0;
        end
        if (full) pend = 4'b0000;
    endtask

    task automatic model_frame();
        int tx, ty;
        bit bot;
        tx = (right_k && !left_k) ? 64 : ((left_k && !right_k) ? -64 : 0);
        ty = (down_k && !up_k) ? 64 : ((up_k && !down_k) ? -64 : 0);
        for (int g = 0; g < 2; g++) begin
            mvx[g] = ramp(mvx[g], tx);
            if (g == 1) begin
                if (up_k && !mpu[g] && mgr[g]) begin
                    mvy[g] = -320; mgr[g] = 1'b0;
                end else begin
                    mvy[g] = (mvy[g] + 8 > 512) ? 512 : mvy[g] + 8;
                end
            end else begin
                mvy[g] = ramp(mvy[g], ty);
            end
            mpu[g] = up_k;
            if (pend[3] && mvx[g] < 0) mvx[g] = 0;
            if (pend[1] && mvx[g] > 0) mvx[g] = 0;
            if (pend[2] && mvy[g] < 0) mvy[g] = 0;
            if (pend[0] && mvy[g] > 0) mvy[g] = 0;
            if (pend[0] && g == 1) mgr[g] = 1'b1;
            mx[g] += mvx[g];
            my[g] += mvy[g];
            bot = 1'b0;
            if (mx[g] < XMIN) begin mx[g] = XMIN; if (mvx[g] < 0) mvx[g] = 0; end
            else if (mx[g] > XMAX) begin mx[g] = XMAX; if (mvx[g] > 0) mvx[g] = 0; end
            if (my[g] < YMIN) begin my[g] = YMIN; if (mvy[g] < 0) mvy[g] = 0; end
            else if (my[g] > YMAX) begin my[g] = YMAX; if (mvy[g] > 0) mvy[g] = 0; bot = 1'b1; end
            if (g == 1) begin
                if (bot) mgr[g] = 1'b1;
                else if (mvy[g] > 0) mgr[g] = 1'b0;
            end
        end
        pend = 4'b0000;
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_xf"}, int'(xf), mx[0] >>> 6);
        check({tag, "_yf"}, int'(yf), my[0] >>> 6);
        check({tag, "_mf"}, int'(mf), int'(mvx[0] != 0 || mvy[0] != 0));
        check({tag, "_gf"}, int'(gf), 0);
        check({tag, "_xg"}, int'(xg), mx[1] >>> 6);
        check({tag, "_yg"}, int'(yg), my[1] >>> 6);
        check({tag, "_mg"}, int'(mg), int'(mvx[1] != 0 || mvy[1] != 0));
        check({tag, "_gg"}, int'(gg), int'(mgr[1]));
    endtask

    task automatic set_keys(input logic [3:0] k);
        {up_k, down_k, left_k, right_k} = k;
    endtask

    task automatic pulse_hit(input logic [3:0] e);
        @(negedge clk); collision = 1'b1; hit = e;
        @(negedge clk); collision = 1'b0; hit = 4'b0000;
        pend |= e;
    endtask

    // SOF pulse, then sample once LIMIT_ST has completed (4 edges later).
    task automatic do_frame(input string tag);
        @(negedge clk); startOfFrame = 1'b1;
        @(negedge clk); startOfFrame = 1'b0;
        repeat (3) @(negedge clk);
        if (!freeze) model_frame();
        compare_model(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'b0001, 280, 185, 1'b1};
        tbl[1]  = '{4'b0001, 280, 185, 1'b1};
        tbl[2]  = '{4'b0001, 281, 185, 1'b1};
        tbl[3]  = '{4'b0001, 282, 185, 1'b1};
        tbl[4]  = '{4'b0000, 283, 185, 1'b1};
        tbl[5]  = '{4'b0000, 283, 185, 1'b1};
        tbl[6]  = '{4'b0000, 284, 185, 1'b1};
        tbl[7]  = '{4'b0000, 284, 185, 1'b0};
        tbl[8]  = '{4'b0011, 284, 185, 1'b0};
        tbl[9]  = '{4'b0100, 284, 185, 1'b1};
        tbl[10] = '{4'b1100, 284, 185, 1'b0};
        tbl[11] = '{4'b1000, 284, 185, 1'b1};
        tbl[12] = '{4'b0000, 284, 185, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_xf", int'(xf), 0);
        check("rst_yf", int'(yf), 0);
        check("rst_mf", int'(mf), 0);
        check("rst_xg", int'(xg), 0);
        check("rst_gg", int'(gg), 0);
        reset = 1'b0;
        model_init(1'b1);
        repeat (2) @(negedge clk);
        check("init_xf", int'(xf), 280);
        check("init_yf", int'(yf), 185);
        compare_model("init");

        // Directed ramp / release / both-keys table.
        for (int i = 0; i < 13; i++) begin
            set_keys(tbl[i].keys);
            do_frame("tbl");
            check("tbl_x", int'(xf), tbl[i].ex);
            check("tbl_y", int'(yf), tbl[i].ey);
            check("tbl_mov", int'(mf), int'(tbl[i].emov));
        end

        // Right-edge collision stops rightward motion for exactly one frame.
        set_keys(4'b0001);
        repeat (4) do_frame("pre_col");
        xhold = mx[0] >>> 6;
        pulse_hit(4'b0010);
        do_frame("col");
        check("col_hold_x", int'(xf), xhold);
        check("col_stop", int'(mf), 0);
        do_frame("col_after");
        check("col_latch_clear", int'(mf), 1);

        // Long left hold: saturate at the left margin; gravity instance lands.
        set_keys(4'b0010);
        repeat (350) do_frame("left");
        check("left_sat_x", int'(xf), 2);
        check("left_sat_mov", int'(mf), 0);
        check("land_y", int'(yg), 445);
        check("land_grounded", int'(gg), 1);

        // Jump, then keep up held: no second jump.
        set_keys(4'b1000);
        do_frame("jump");
        check("jump_y", int'(yg), 440);
        check("jump_grounded", int'(gg), 0);
        repeat (200) do_frame("hold_up");
        check("no_rejump_y", int'(yg), 445);
        check("no_rejump_grounded", int'(gg), 1);

        // Freeze across three frame pulses.
        xhold = mx[0] >>> 6;
        yhold = my[0] >>> 6;
        freeze = 1'b1;
        set_keys(4'b0101);
        repeat (3) do_frame("freeze");
        check("freeze_x", int'(xf), xhold);
        check("freeze_y", int'(yf), yhold);
        freeze = 1'b0;

        // Restart while POS_ST is active.
        set_keys(4'b0001);
        repeat (2) do_frame("pre_rs");
        set_keys(4'b0000);
        @(negedge clk); startOfFrame = 1'b1;
        @(negedge clk); startOfFrame = 1'b0;
        @(negedge clk); restart = 1'b1;
        @(negedge clk); restart = 1'b0;
        @(negedge clk);
        model_init(1'b0);
        // The interrupted frame still passed SPEED_ST: up sampled, edges consumed.
        mpu[0] = up_k; mpu[1] = up_k; pend = 4'b0000;
        check("rs_x", int'(xf), 280);
        check("rs_y", int'(yf), 185);
        check("rs_mov", int'(mf), 0);
        compare_model("rs");
        do_frame("post_rs");
        check("post_rs_x", int'(xf), 280);
        check("post_rs_mov", int'(mf), 0);

        // Asynchronous reset in the middle of a frame.
        set_keys(4'b0001);
        repeat (2) do_frame("pre_rst");
        @(negedge clk); startOfFrame = 1'b1;
        @(negedge clk); startOfFrame = 1'b0;
        @(negedge clk); reset = 1'b1;
        #1;
        check("arst_xf", int'(xf), 0);
        check("arst_yf", int'(yf), 0);
        check("arst_mf", int'(mf), 0);
        check("arst_xg", int'(xg), 0);
        check("arst_yg", int'(yg), 0);
        check("arst_gg", int'(gg), 0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        model_init(1'b1);
        compare_model("post_arst");

        // Randomized frames against the model.
        for (int i = 0; i < 200; i++) begin
            set_keys(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) pulse_hit(4'($urandom_range(0, 15)));
            freeze = ($urandom_range(0, 7) == 0);
            do_frame("rnd");
            freeze = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/object_move_gen.md
Name: object_move_gen

Overview:
- Parametrised successor of the keyboard-driven player mover.
- Produces the top-left pixel position of one sprite each frame, using fixed-point position and speed registers.
- Adds a speed ramp (acceleration and deceleration toward a target speed), an optional gravity/jump mode, sticky collision latching across a frame, and a freeze/restart control.
- Sits between keyboard decode / collision detection and the sprite drawing block.

Parameters:
- POS_W, 11, width of signed topLeftX/topLeftY outputs.
- FRAC_BITS, 6, fixed-point fraction bits (multiplier = 2^FRAC_BITS).
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.
- OBJ_W, 32, sprite width in pixels.
- OBJ_H, 32, sprite height in pixels.
- MARGIN, 2, safety margin in pixels.
- INIT_X, 280, initial X in pixels.
- INIT_Y, 185, initial Y in pixels.
- MAX_SPEED, 64, absolute target speed per axis, in fixed-point units per frame.
- ACCEL, 16, speed step per frame toward the target.
- GRAVITY_EN, 0, 0 = free 4-way mode, 1 = gravity/jump mode.
- GRAVITY, 8, Y speed added per frame when GRAVITY_EN=1.
- MAX_FALL, 512, positive Y speed cap when GRAVITY_EN=1.
- JUMP_SPEED, 320, upward speed magnitude applied on a jump.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per frame
- up_key_pressed  in  1  level
- down_key_pressed  in  1  level
- left_key_pressed  in  1  level
- right_key_pressed  in  1  level
- collision  in  1  sprite overlaps an obstacle this cycle
- HitEdgeCode  in  4  [3]=left, [2]=top, [1]=right, [0]=bottom edge hit
- freeze  in  1  hold position and speed; frames are ignored
- restart  in  1  synchronous pulse: return to the initial position
- topLeftX  out  POS_W  signed pixel X
- topLeftY  out  POS_W  signed pixel Y
- moving  out  1  any speed component nonzero
- grounded  out  1  resting on floor or obstacle (gravity mode only; 0 otherwise)

Behaviour:
- Reset: state INIT_ST; all speeds 0, positions 0, collision latch 0, grounded 0, previous-up register 0.
  - topLeftX = topLeftY = 0 and moving = 0 during reset.
- FSM: INIT_ST -> WAIT_SOF_ST -> SPEED_ST -> POS_ST -> LIMIT_ST -> WAIT_SOF_ST.
- INIT_ST: position = INIT_X/INIT_Y shifted left by FRAC_BITS; speeds 0; grounded 0; go to WAIT_SOF_ST.
- WAIT_SOF_ST: on startOfFrame with freeze=0, go to SPEED_ST. startOfFrame is ignored while freeze=1.
- Collision latch: any cycle with collision=1 ORs HitEdgeCode into a 4-bit sticky register. The latch is cleared on exit from SPEED_ST. A collision arriving in that same cycle is kept (set wins over clear).
- SPEED_ST, per axis:
  - Target = +MAX_SPEED or -MAX_SPEED if exactly one key of the pair is pressed, else 0.
  - Speed moves toward target by ACCEL, clamped so it never overshoots the target.
- SPEED_ST, gravity mode (GRAVITY_EN=1), Y axis only:
  - Y keys are ignored; Yspeed += GRAVITY, capped at MAX_FALL.
  - Jump: up key rising edge (up_key_pressed now 1, previous-frame sample 0) while grounded=1 sets Yspeed = -JUMP_SPEED and clears grounded. Jump overrides gravity for that frame.
- SPEED_ST, latched edges (applied after the ramp, in the same state):
  - [2] zeroes negative Yspeed.
  - [0] zeroes positive Yspeed and, in gravity mode, sets grounded.
  - [3] zeroes negative Xspeed.
  - [1] zeroes positive Xspeed.
- POS_ST: position += speed, both axes.
- LIMIT_ST: clamp each axis to [MARGIN, SCREEN-1-MARGIN-OBJ] pixels, in fixed point.
  - A clamp zeroes the speed component pointing outward.
  - A bottom clamp in gravity mode sets grounded.
  - In gravity mode, grounded clears at LIMIT_ST if Yspeed > 0 and no bottom clamp occurred.
  - Defaults: X range [2,605], Y range [2,445].
- restart: from any state, next state is INIT_ST. Takes priority over freeze and startOfFrame.
- Arithmetic: internal registers are signed 32-bit. Outputs are position arithmetic-shifted right by FRAC_BITS (floor), truncated to POS_W.
- Latency: position updates 2 cycles after the startOfFrame pulse (SPEED_ST, then POS_ST registers). Clamp is applied 1 cycle later.
- Both keys of a pair pressed counts as no key on that axis.
- Outputs are purely registered-state derived; no combinational path from inputs.

Decomposition:
- Package obj_move_pkg holds:
  - the state enum;
  - the HitEdgeCode bit-index constants (EDGE_LEFT=3, EDGE_TOP=2, EDGE_RIGHT=1, EDGE_BOTTOM=0);
  - a function computing a frame limit from screen size, object size and margin.
- One sub-module, speed_ramp: combinational per-axis step of speed toward target by ACCEL with no overshoot. Instantiated twice (X, and Y in free mode).

Test Plan:
- Free mode, defaults, hold right key 4 frames -> Xspeed 16, 32, 48, 64; topLeftX 280 -> 282 (fixed point 17920 + 160 = 18080); topLeftY stays 185.
- Release right after reaching 64 -> speed steps 48, 32, 16, 0; moving drops to 0 in frame 4.
- Hold left for many frames -> topLeftX saturates at 2, Xspeed = 0; left and right held together -> target 0.
- Collision pulse with HitEdgeCode = 4'b0010 mid-frame while moving right -> next SPEED_ST zeroes Xspeed; latch reads 0 afterwards.
- Gravity mode: fall to topLeftY = 445 -> grounded = 1; press up -> Yspeed = -320, grounded = 0; holding up gives no second jump.
- freeze held across 3 startOfFrame pulses -> outputs unchanged. restart pulse mid-POS_ST -> (280,185), speeds 0 on the next frame. Assert reset mid-motion -> outputs 0 immediately.
